// File: rtl/wb_stage_ex_pkg.sv
// Shared widths, MEM->WB bus sizing and exception codes for the WB stage.
package wb_stage_ex_pkg;

  // Default field widths of the MEM->WB payload.
  localparam int WB_DATA_W  = 32;
  localparam int WB_RIDX_W  = 5;
  localparam int WB_CSR_W   = 14;
  localparam int WB_ECODE_W = 6;
  localparam int WB_CNT_W   = 64;

  // Width of the packed MEM->WB bus:
  // {gr_we, dest, result, pc, ex, ecode, ertn, csr_we, csr_num, csr_wmask, csr_wdata}
  function automatic int mem_to_wb_bus_w(input int data_w, input int ridx_w,
                                         input int csr_w, input int ecode_w);
    return 1 + ridx_w + data_w + data_w + 1 + ecode_w + 1 + 1 + csr_w + data_w + data_w;
  endfunction

  localparam int MEM_TO_WB_BUS_W =
    mem_to_wb_bus_w(WB_DATA_W, WB_RIDX_W, WB_CSR_W, WB_ECODE_W);

  // LoongArch exception codes.
  localparam logic [WB_ECODE_W-1:0] ECODE_INT = 6'h00;
  localparam logic [WB_ECODE_W-1:0] ECODE_PIL = 6'h01;
  localparam logic [WB_ECODE_W-1:0] ECODE_PIS = 6'h02;
  localparam logic [WB_ECODE_W-1:0] ECODE_PIF = 6'h03;
  localparam logic [WB_ECODE_W-1:0] ECODE_PME = 6'h04;
  localparam logic [WB_ECODE_W-1:0] ECODE_PPI = 6'h07;
  localparam logic [WB_ECODE_W-1:0] ECODE_ADE = 6'h08;
  localparam logic [WB_ECODE_W-1:0] ECODE_ALE = 6'h09;
  localparam logic [WB_ECODE_W-1:0] ECODE_SYS = 6'h0B;
  localparam logic [WB_ECODE_W-1:0] ECODE_BRK = 6'h0C;
  localparam logic [WB_ECODE_W-1:0] ECODE_INE = 6'h0D;
  localparam logic [WB_ECODE_W-1:0] ECODE_IPE = 6'h0E;
  localparam logic [WB_ECODE_W-1:0] ECODE_FPD = 6'h0F;
  localparam logic [WB_ECODE_W-1:0] ECODE_TLBR = 6'h3F;

endpackage

// File: rtl/wb_commit_ctr.sv
// Retired-instruction counter: increments by one on each enabled cycle,
// wraps modulo 2^CNT_W, cleared by synchronous active-low reset.
module wb_commit_ctr #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: hold unless a retiring instruction enables the increment.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment to avoid ordering races.
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_stage_ex.sv
// Writeback stage: holds the instruction from MEM, commits it to the
// regfile/CSR unit, raises exception/ERTN flushes and counts retirements.
module wb_stage_ex
  import wb_stage_ex_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RIDX_W  = WB_RIDX_W,
  parameter int CSR_W   = WB_CSR_W,
  parameter int ECODE_W = WB_ECODE_W,
  parameter int CNT_W   = WB_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  // MEM -> WB
  input  logic               mem_to_wb_valid,
  input  logic               mem_gr_we,
  input  logic [RIDX_W-1:0]  mem_dest,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic [DATA_W-1:0]  mem_pc,
  input  logic               mem_ex,
  input  logic [ECODE_W-1:0] mem_ecode,
  input  logic               mem_ertn,
  input  logic               mem_csr_we,
  input  logic [CSR_W-1:0]   mem_csr_num,
  input  logic [DATA_W-1:0]  mem_csr_wmask,
  input  logic [DATA_W-1:0]  mem_csr_wdata,
  // CSR unit
  input  logic               ext_stall,
  input  logic [DATA_W-1:0]  csr_eentry,
  input  logic [DATA_W-1:0]  csr_era,
  // Handshake
  output logic               wb_allow_in,
  // Regfile write port
  output logic               rf_we,
  output logic [RIDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  // Hazard info to ID
  output logic               wb_valid,
  output logic               wb_gr_we,
  output logic [RIDX_W-1:0]  wb_dest,
  // CSR commit
  output logic               csr_we,
  output logic [CSR_W-1:0]   csr_num,
  output logic [DATA_W-1:0]  csr_wmask,
  output logic [DATA_W-1:0]  csr_wdata,
  // Exception / ERTN to CSR unit
  output logic               wb_ex,
  output logic [ECODE_W-1:0] wb_ecode,
  output logic [DATA_W-1:0]  wb_ex_pc,
  output logic               wb_ertn,
  // Flush / redirect
  output logic               wb_flush,
  output logic [DATA_W-1:0]  wb_flush_target,
  // Retired count
  output logic [CNT_W-1:0]   instret,
  // Debug trace
  output logic [DATA_W-1:0]  debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [RIDX_W-1:0]  debug_wb_rf_wnum,
  output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

  localparam int BUS_W = mem_to_wb_bus_w(DATA_W, RIDX_W, CSR_W, ECODE_W);

  logic [BUS_W-1:0] mem_bus;
  logic [BUS_W-1:0] bus_q;
  logic [BUS_W-1:0] bus_d;
  logic             valid_q;
  logic             valid_d;

  // Unpacked view of the held payload.
  logic               p_gr_we;
  logic [RIDX_W-1:0]  p_dest;
  logic [DATA_W-1:0]  p_result;
  logic [DATA_W-1:0]  p_pc;
  logic               p_ex;
  logic [ECODE_W-1:0] p_ecode;
  logic               p_ertn;
  logic               p_csr_we;
  logic [CSR_W-1:0]   p_csr_num;
  logic [DATA_W-1:0]  p_csr_wmask;
  logic [DATA_W-1:0]  p_csr_wdata;

  logic ready_go;
  logic commit;
  logic ex_commit;
  logic ertn_commit;
  logic retire;

  assign mem_bus = {mem_gr_we, mem_dest, mem_result, mem_pc,
                    mem_ex, mem_ecode, mem_ertn,
                    mem_csr_we, mem_csr_num, mem_csr_wmask, mem_csr_wdata};

  assign {p_gr_we, p_dest, p_result, p_pc,
          p_ex, p_ecode, p_ertn,
          p_csr_we, p_csr_num, p_csr_wmask, p_csr_wdata} = bus_q;

  // Handshake and commit qualification. Reset blocks commit so a held
  // instruction is dropped if reset arrives while it waits.
  assign ready_go    = !ext_stall;
  assign wb_allow_in = !valid_q || ready_go;
  assign commit      = valid_q && ready_go && resetn;
  assign ex_commit   = commit && p_ex;
  assign ertn_commit = commit && !p_ex && p_ertn;
  assign retire      = commit && !p_ex;

  // Next-state for the valid bit and payload; a flush discards the
  // instruction arriving in the same cycle.
  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    if (wb_allow_in) begin
      valid_d = mem_to_wb_valid && !wb_flush;
      if (mem_to_wb_valid) begin
        bus_d = mem_bus;
      end
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

  // Commit outputs: all zero unless an instruction commits this cycle.
  always_comb begin
    rf_we           = 1'b0;
    rf_waddr        = '0;
    rf_wdata        = '0;
    csr_we          = 1'b0;
    csr_num         = '0;
    csr_wmask       = '0;
    csr_wdata       = '0;
    wb_ex           = 1'b0;
    wb_ecode        = '0;
    wb_ex_pc        = '0;
    wb_ertn         = 1'b0;
    wb_flush        = 1'b0;
    wb_flush_target = '0;
    if (ex_commit) begin
      wb_ex           = 1'b1;
      wb_ecode        = p_ecode;
      wb_ex_pc        = p_pc;
      wb_flush        = 1'b1;
      wb_flush_target = csr_eentry;
    end else if (ertn_commit) begin
      wb_ertn         = 1'b1;
      wb_flush        = 1'b1;
      wb_flush_target = csr_era;
    end else if (commit) begin
      rf_we = p_gr_we;
      if (p_gr_we) begin
        rf_waddr = p_dest;
        rf_wdata = p_result;
      end
    end
    if (retire && p_csr_we) begin
      csr_we    = 1'b1;
      csr_num   = p_csr_num;
      csr_wmask = p_csr_wmask;
      csr_wdata = p_csr_wdata;
    end
  end

  // Hazard info reflects the held instruction even while stalled.
  assign wb_valid = valid_q;
  assign wb_gr_we = valid_q && p_gr_we && !p_ex;
  assign wb_dest  = p_dest;

  // Debug trace mirrors the regfile port.
  assign debug_wb_pc       = p_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  wb_commit_ctr #(
    .CNT_W (CNT_W)
  ) u_instret (
    .clk     (clk),
    .resetn  (resetn),
    .en_i    (retire),
    .count_o (instret)
  );

endmodule

// File: tb/tb_wb_stage_ex.sv
// Directed self-checking bench for wb_stage_ex (instret narrowed to 4 bits).
module tb_wb_stage_ex;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 14;
  localparam int EW = 6;
  localparam int NW = 4;

  localparam logic [DW-1:0] EENTRY = 32'h1C008000;
  localparam logic [DW-1:0] ERA    = 32'h1C000024;

  typedef struct {
    logic          valid;
    logic          gr_we;
    logic [RW-1:0] dest;
    logic [DW-1:0] result;
    logic [DW-1:0] pc;
    logic          ex;
    logic [EW-1:0] ecode;
    logic          ertn;
    logic          csr_we;
    logic [CW-1:0] csr_num;
    logic [DW-1:0] csr_wmask;
    logic [DW-1:0] csr_wdata;
  } in_t;

  typedef struct {
    in_t           in;
    logic          rf_we;
    logic [RW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          valid;
    logic          flush;
    logic [DW-1:0] target;
    logic          csr_we;
    logic [DW-1:0] csr_wmask;
    logic [DW-1:0] csr_wdata;
    logic [NW-1:0] instret;
  } vec_t;

  logic clk, resetn;
  logic mem_to_wb_valid, mem_gr_we, mem_ex, mem_ertn, mem_csr_we, ext_stall;
  logic [RW-1:0] mem_dest;
  logic [DW-1:0] mem_result, mem_pc, mem_csr_wmask, mem_csr_wdata, csr_eentry, csr_era;
  logic [EW-1:0] mem_ecode;
  logic [CW-1:0] mem_csr_num;
  logic wb_allow_in, rf_we, wb_valid, wb_gr_we, csr_we, wb_ex, wb_ertn, wb_flush;
  logic [RW-1:0] rf_waddr, wb_dest, debug_wb_rf_wnum;
  logic [DW-1:0] rf_wdata, csr_wmask, csr_wdata, wb_ex_pc, wb_flush_target;
  logic [DW-1:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [CW-1:0] csr_num;
  logic [EW-1:0] wb_ecode;
  logic [NW-1:0] instret;
  logic [3:0]    debug_wb_rf_we;

  int total = 0;
  int bad   = 0;
  vec_t vecs [10];

  wb_stage_ex #(.DATA_W(DW), .RIDX_W(RW), .CSR_W(CW), .ECODE_W(EW), .CNT_W(NW)) dut (
    .clk(clk), .resetn(resetn),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_gr_we(mem_gr_we), .mem_dest(mem_dest),
    .mem_result(mem_result), .mem_pc(mem_pc), .mem_ex(mem_ex), .mem_ecode(mem_ecode),
    .mem_ertn(mem_ertn), .mem_csr_we(mem_csr_we), .mem_csr_num(mem_csr_num),
    .mem_csr_wmask(mem_csr_wmask), .mem_csr_wdata(mem_csr_wdata),
    .ext_stall(ext_stall), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .wb_allow_in(wb_allow_in), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_ex_pc(wb_ex_pc), .wb_ertn(wb_ertn),
    .wb_flush(wb_flush), .wb_flush_target(wb_flush_target), .instret(instret),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x.valid = 0; x.gr_we = 0; x.dest = '0; x.result = '0; x.pc = '0;
    x.ex = 0; x.ecode = '0; x.ertn = 0; x.csr_we = 0; x.csr_num = '0;
    x.csr_wmask = '0; x.csr_wdata = '0;
    return x;
  endfunction

  function automatic in_t alu(input logic [RW-1:0] d, input logic [DW-1:0] r, input logic [DW-1:0] p);
    in_t x;
    x = idle();
    x.valid = 1; x.gr_we = 1; x.dest = d; x.result = r; x.pc = p;
    return x;
  endfunction

  task automatic drive(input in_t x);
    mem_to_wb_valid = x.valid; mem_gr_we = x.gr_we; mem_dest = x.dest;
    mem_result = x.result; mem_pc = x.pc; mem_ex = x.ex; mem_ecode = x.ecode;
    mem_ertn = x.ertn; mem_csr_we = x.csr_we; mem_csr_num = x.csr_num;
    mem_csr_wmask = x.csr_wmask; mem_csr_wdata = x.csr_wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input in_t x, input logic e_we, input logic [RW-1:0] e_a,
                         input logic [DW-1:0] e_d, input logic e_v, input logic e_fl,
                         input logic [DW-1:0] e_t, input logic e_cwe, input logic [DW-1:0] e_cm,
                         input logic [DW-1:0] e_cd, input logic [NW-1:0] e_n);
    vecs[i].in = x; vecs[i].rf_we = e_we; vecs[i].waddr = e_a; vecs[i].wdata = e_d;
    vecs[i].valid = e_v; vecs[i].flush = e_fl; vecs[i].target = e_t;
    vecs[i].csr_we = e_cwe; vecs[i].csr_wmask = e_cm; vecs[i].csr_wdata = e_cd;
    vecs[i].instret = e_n;
  endtask

  initial begin
    in_t x;
    logic [NW-1:0] exp_cnt;

    // ---------------- reset ----------------
    resetn = 0; ext_stall = 0; csr_eentry = EENTRY; csr_era = ERA;
    drive(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_flush", 64'(wb_flush), 64'd0);
    check("rst_dbg_pc", 64'(debug_wb_pc), 64'd0);
    @(posedge clk); #1;
    resetn = 1;

    // ---------------- table-driven vectors ----------------
    set_vec(0, alu(5'd5, 32'h1234, 32'h1C000000), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    set_vec(1, alu(5'd6, 32'hABCD, 32'h1C000004), 1, 5, 32'h1234, 1, 0, 0, 0, 0, 0, 4'd0);
    set_vec(2, idle(), 1, 6, 32'hABCD, 1, 0, 0, 0, 0, 0, 4'd1);
    set_vec(3, idle(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd2);
    x = idle(); x.valid = 1; x.pc = 32'h1C000008;
    x.csr_we = 1; x.csr_num = 14'h0; x.csr_wmask = 32'h7; x.csr_wdata = 32'h3;
    set_vec(4, x, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd2);
    set_vec(5, idle(), 0, 0, 0, 1, 0, 0, 1, 32'h7, 32'h3, 4'd2);
    set_vec(6, idle(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3);
    x = alu(5'd7, 32'h55, 32'h1C00000C); x.ertn = 1;
    set_vec(7, x, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3);
    set_vec(8, idle(), 0, 0, 0, 1, 1, ERA, 0, 0, 0, 4'd3);
    set_vec(9, idle(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd4);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].in);
      @(negedge clk);
      check($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].rf_we));
      check($sformatf("v%0d_dbg_we", i), 64'(debug_wb_rf_we), 64'({4{vecs[i].rf_we}}));
      check($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].waddr));
      check($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].wdata));
      check($sformatf("v%0d_valid", i), 64'(wb_valid), 64'(vecs[i].valid));
      check($sformatf("v%0d_flush", i), 64'(wb_flush), 64'(vecs[i].flush));
      check($sformatf("v%0d_target", i), 64'(wb_flush_target), 64'(vecs[i].target));
      check($sformatf("v%0d_csr_we", i), 64'(csr_we), 64'(vecs[i].csr_we));
      check($sformatf("v%0d_csr_wmask", i), 64'(csr_wmask), 64'(vecs[i].csr_wmask));
      check($sformatf("v%0d_csr_wdata", i), 64'(csr_wdata), 64'(vecs[i].csr_wdata));
      check($sformatf("v%0d_instret", i), 64'(instret), 64'(vecs[i].instret));
      next_cycle();
    end
    exp_cnt = 4'd4;

    // ---------------- stall: held 3 cycles, commits once ----------------
    drive(alu(5'd9, 32'h99, 32'h1C000020));
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      ext_stall = 1;
      drive(alu(5'd10, 32'hAA, 32'h1C000024));
      @(negedge clk);
      check("stall_allow_in", 64'(wb_allow_in), 64'd0);
      check("stall_rf_we", 64'(rf_we), 64'd0);
      check("stall_valid", 64'(wb_valid), 64'd1);
      check("stall_dest", 64'(wb_dest), 64'd9);
      check("stall_dbg_pc", 64'(debug_wb_pc), 64'h1C000020);
      check("stall_instret", 64'(instret), 64'(exp_cnt));
      next_cycle();
    end
    ext_stall = 0;
    @(negedge clk);
    check("release_rf_we", 64'(rf_we), 64'd1);
    check("release_waddr", 64'(rf_waddr), 64'd9);
    check("release_wdata", 64'(rf_wdata), 64'h99);
    check("release_allow_in", 64'(wb_allow_in), 64'd1);
    next_cycle();
    exp_cnt = exp_cnt + 1'b1;
    drive(idle());
    @(negedge clk);
    check("release_once_instret", 64'(instret), 64'(exp_cnt));
    check("next_waddr", 64'(rf_waddr), 64'd10);
    next_cycle();
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    check("after_next_instret", 64'(instret), 64'(exp_cnt));
    check("after_next_rf_we", 64'(rf_we), 64'd0);

    // ---------------- exception with follower in flush cycle ----------------
    x = alu(5'd3, 32'h77, 32'h1C000010);
    x.ex = 1; x.ecode = 6'h0B;
    x.csr_we = 1; x.csr_num = 14'h1; x.csr_wmask = 32'hF; x.csr_wdata = 32'h5;
    drive(x);
    next_cycle();
    drive(alu(5'd4, 32'h44, 32'h1C000014));
    @(negedge clk);
    check("ex_flush", 64'(wb_flush), 64'd1);
    check("ex_target", 64'(wb_flush_target), 64'(EENTRY));
    check("ex_rf_we", 64'(rf_we), 64'd0);
    check("ex_csr_we", 64'(csr_we), 64'd0);
    check("ex_wb_ex", 64'(wb_ex), 64'd1);
    check("ex_ecode", 64'(wb_ecode), 64'h0B);
    check("ex_pc", 64'(wb_ex_pc), 64'h1C000010);
    check("ex_gr_we_hazard", 64'(wb_gr_we), 64'd0);
    next_cycle();
    drive(idle());
    @(negedge clk);
    check("ex_follower_dropped", 64'(wb_valid), 64'd0);
    check("ex_flush_pulse", 64'(wb_flush), 64'd0);
    check("ex_rf_we_after", 64'(rf_we), 64'd0);
    check("ex_instret", 64'(instret), 64'(exp_cnt));
    next_cycle();

    // ---------------- ex and ertn together: ex wins ----------------
    x = idle(); x.valid = 1; x.pc = 32'h1C000030; x.ex = 1; x.ertn = 1; x.ecode = 6'h0D;
    drive(x);
    next_cycle();
    drive(idle());
    @(negedge clk);
    check("prio_target", 64'(wb_flush_target), 64'(EENTRY));
    check("prio_wb_ex", 64'(wb_ex), 64'd1);
    check("prio_wb_ertn", 64'(wb_ertn), 64'd0);
    next_cycle();
    @(negedge clk);
    check("prio_instret", 64'(instret), 64'(exp_cnt));

    // ---------------- counter wrap: 17 commits from reset ----------------
    resetn = 0;
    next_cycle();
    resetn = 1;
    for (int i = 0; i < 17; i++) begin
      drive(alu(5'(i + 1), 32'(i), 32'h1C001000 + 32'(i * 4)));
      next_cycle();
    end
    drive(idle());
    @(negedge clk);
    check("wrap_at_16", 64'(instret), 64'd0);
    next_cycle();
    @(negedge clk);
    check("wrap_17", 64'(instret), 64'd1);

    // ---------------- reset mid-stall drops held instruction ----------------
    drive(alu(5'd12, 32'hC0DE, 32'h1C002000));
    next_cycle();
    drive(idle());
    ext_stall = 1;
    @(negedge clk);
    check("rst_mid_held", 64'(wb_valid), 64'd1);
    next_cycle();
    resetn = 0;
    ext_stall = 0;
    @(negedge clk);
    check("rst_mid_no_commit", 64'(rf_we), 64'd0);
    next_cycle();
    resetn = 1;
    @(negedge clk);
    check("rst_mid_valid", 64'(wb_valid), 64'd0);
    check("rst_mid_instret", 64'(instret), 64'd0);
    check("rst_mid_rf_we", 64'(rf_we), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
